// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until the downstream
// consumer acknowledges it; the acknowledging edge re-arbitrates with no bubble.
module rr_onehot_arbiter #(
    parameter int unsigned NUMBER_WAYS = 8,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [NUMBER_WAYS-1:0] request_in,
    input  logic                   issue_ack_in,
    output logic [NUMBER_WAYS-1:0] grant_out,
    output logic                   grant_valid_out,
    output logic [INDEX_WIDTH-1:0] grant_index_out
);

    typedef enum logic {StIdle, StGranted} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [NUMBER_WAYS-1:0] grant_q, grant_d;
    logic                   armed_q;

    logic [INDEX_WIDTH-1:0] search_base;
    logic [INDEX_WIDTH-1:0] candidate;
    logic [INDEX_WIDTH-1:0] found_index;
    logic                   found;

    // On an ack the just-served way drops to lowest priority, so the search
    // starts one past it; otherwise it starts at the stored pointer.
    always_comb begin
        search_base = (state_q == StGranted) ? INDEX_WIDTH'(index_q + 1'b1) : ptr_q;
        found       = 1'b0;
        found_index = '0;
        candidate   = '0;
        for (int unsigned i = 0; i < NUMBER_WAYS; i++) begin
            candidate = search_base + INDEX_WIDTH'(i);
            if (!found && request_in[candidate]) begin
                found       = 1'b1;
                found_index = candidate;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        index_d = index_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (armed_q && found) begin
                    state_d = StGranted;
                    index_d = found_index;
                    grant_d = NUMBER_WAYS'(1) << found_index;
                end
            end
            StGranted: begin
                if (issue_ack_in) begin
                    ptr_d = search_base;
                    if (found) begin
                        index_d = found_index;
                        grant_d = NUMBER_WAYS'(1) << found_index;
                    end else begin
                        state_d = StIdle;
                        index_d = '0;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // armed_q holds off the first grant until the second edge after reset release.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            index_q <= '0;
            grant_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            index_q <= index_d;
            grant_q <= grant_d;
            armed_q <= 1'b1;
        end
    end

    assign grant_out       = grant_q;
    assign grant_valid_out = (state_q == StGranted);
    assign grant_index_out = index_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed vector table, reset/rotation sequences,
// then random traffic against a search-based reference model.
module tb_rr_onehot_arbiter;

    localparam int N = 8;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic [N-1:0] request_in;
    logic         issue_ack_in;
    logic [N-1:0] grant_out;
    logic         grant_valid_out;
    logic [2:0]   grant_index_out;

    rr_onehot_arbiter #(.NUMBER_WAYS(N), .INDEX_WIDTH(3)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .request_in      (request_in),
        .issue_ack_in    (issue_ack_in),
        .grant_out       (grant_out),
        .grant_valid_out (grant_valid_out),
        .grant_index_out (grant_index_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] req;
        logic       ack;
        logic [7:0] grant;
        logic       valid;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a grant is just "which way, if any"; selection is the
    // first requester met walking circularly upward from the priority pointer.
    int m_ptr, m_idx;
    bit m_valid, m_armed;

    function automatic int circ_search(logic [7:0] r, int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_valid = 0; m_armed = 0;
    endtask

    task automatic model_step(logic [7:0] r, logic a);
        int j;
        if (!m_armed) begin
            m_armed = 1;
        end else if (!m_valid) begin
            j = circ_search(r, m_ptr);
            if (j >= 0) begin m_idx = j; m_valid = 1; end
        end else if (a) begin
            m_ptr = (m_idx + 1) % N;
            j = circ_search(r, m_ptr);
            if (j >= 0) m_idx = j;
            else begin m_valid = 0; m_idx = 0; end
        end
    endtask

    task automatic check(string name, logic [7:0] eg, logic ev, logic [2:0] ei);
        vectors++;
        if (grant_out !== eg || grant_valid_out !== ev || grant_index_out !== ei) begin
            miscompares++;
            $display("FAIL %s: got grant=%h valid=%b index=%0d, expected grant=%h valid=%b index=%0d",
                     name, grant_out, grant_valid_out, grant_index_out, eg, ev, ei);
        end
    endtask

    task automatic check_model(string name);
        logic [7:0] eg;
        eg = m_valid ? 8'(1 << m_idx) : 8'h00;
        check(name, eg, m_valid, m_valid ? 3'(m_idx) : 3'd0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // {req, ack, grant, valid, idx}, one row per edge, starting at reset release
        tbl.push_back('{8'h24, 1'b0, 8'h00, 1'b0, 3'd0}); // arming edge: no grant yet
        tbl.push_back('{8'h24, 1'b1, 8'h04, 1'b1, 3'd2}); // ack ignored in idle
        tbl.push_back('{8'h24, 1'b1, 8'h20, 1'b1, 3'd5});
        tbl.push_back('{8'h24, 1'b1, 8'h04, 1'b1, 3'd2});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 3'd0}); // drain, ptr -> 3
        tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 3'd0}); // ack while idle
        tbl.push_back('{8'h08, 1'b0, 8'h08, 1'b1, 3'd3});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{8'h01, 1'b0, 8'h08, 1'b1, 3'd3}); // hold without ack
        tbl.push_back('{8'h01, 1'b1, 8'h01, 1'b1, 3'd0}); // wraps past 7 to way 0
        for (int i = 0; i < 3; i++)
            tbl.push_back('{8'h01, 1'b1, 8'h01, 1'b1, 3'd0}); // re-grant, no bubble
        tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 3'd0});

        // Reset asserted before any clock edge must clear outputs by itself
        reset_in = 1'b1; request_in = 8'hFF; issue_ack_in = 1'b0;
        #2;
        check("reset_async", 8'h00, 1'b0, 3'd0);
        tick();
        reset_in = 1'b0; request_in = 8'h24;

        for (int i = 0; i < tbl.size(); i++) begin
            request_in = tbl[i].req;
            issue_ack_in = tbl[i].ack;
            tick();
            check($sformatf("table[%0d]", i), tbl[i].grant, tbl[i].valid, tbl[i].idx);
        end

        // Grant from ptr=1, then reset mid-grant without an edge
        request_in = 8'hFF; issue_ack_in = 1'b0;
        tick();
        check("pre_reset_grant", 8'h02, 1'b1, 3'd1);
        reset_in = 1'b1;
        #1;
        check("reset_mid_grant", 8'h00, 1'b0, 3'd0);
        tick();
        check("reset_held", 8'h00, 1'b0, 3'd0);
        reset_in = 1'b0; issue_ack_in = 1'b1;
        tick();
        check("release_first_edge", 8'h00, 1'b0, 3'd0);
        for (int k = 0; k <= N; k++) begin
            tick();
            check($sformatf("rotation[%0d]", k), 8'(1 << (k % N)), 1'b1, 3'(k % N));
        end

        // Random traffic against the model
        reset_in = 1'b1;
        model_reset();
        #1;
        check("rand_reset_init", 8'h00, 1'b0, 3'd0);
        tick();
        reset_in = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_in = 1'b1;
                model_reset();
                #1;
                check_model($sformatf("rand_reset[%0d]", n));
                tick();
                reset_in = 1'b0;
            end
            request_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            issue_ack_in = 1'($urandom_range(0, 1));
            model_step(request_in, issue_ack_in);
            tick();
            check_model($sformatf("rand[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
